seq_multiplier: RTL

Parametrised sequential shift-add multiplier: WIDTH×WIDTH → 2·WIDTH product, one multiplier bit per clock, with a start/done handshake and a run-time unsigned/signed (two's complement) mode. It is the general successor of the team's 2-bit combinational array multiplier. It sits in datapaths where area matters more than throughput: one adder of WIDTH+1 bits replaces a full partial-product array.

---
 rtl/seq_mul_pkg.sv | 28 ++
 rtl/seq_multiplier.sv | 113 +++++++++++
 2 files changed

// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg
//   Shared definitions for the sequential shift-add multiplier:
//   - DEFAULT_WIDTH : default operand width
//   - state_t       : controller state encoding (IDLE, RUN, DONE)
//   - cond_neg      : conditional two's-complement negate, used both to take
//                     operand magnitudes and to restore the product sign
package seq_mul_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Widest value cond_neg handles: a 2*32-bit product.
    localparam int NEG_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Callers zero-extend into NEG_W bits and cast the result back down.
    // The low bits of a two's-complement negation do not depend on the
    // upper bits, so the truncated result is exact at any width.
    function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] x,
                                                  input logic             en);
        return en ? (~x + 64'd1) : x;
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier
//   Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one multiplier
//   bit per clock. Signed operands are handled as sign + magnitude: the
//   magnitudes are multiplied unsigned and the product is negated at the end.
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request, sampled only in IDLE
//   signed_mode  1 = two's-complement operands/product, sampled with start
//   a, b         multiplicand / multiplier, sampled with start
//   busy         high while the shift-add loop runs
//   done         one-cycle pulse, p valid from this cycle on
//   p            product, held until the next accepted operation completes
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t               state;
    state_t               next_state;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     mcand;
    // Upper half accumulates partial sums; lower half starts as the
    // multiplier and is shifted out one bit per step as product bits enter.
    logic [2*WIDTH-1:0]   acc;
    logic                 neg;
    logic                 mode;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   product;
    logic                 last;

    // |-2^(WIDTH-1)| = 2^(WIDTH-1) still fits as a WIDTH-bit unsigned value.
    assign mag_a = WIDTH'(cond_neg(64'(a), signed_mode & a[WIDTH-1]));
    assign mag_b = WIDTH'(cond_neg(64'(b), signed_mode & b[WIDTH-1]));

    // WIDTH+1-bit add keeps the carry, which becomes the top bit after shift.
    assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    assign acc_step = {sum, acc[WIDTH-1:1]};
    assign last     = (cnt == CW'(WIDTH - 1));
    assign product  = (2*WIDTH)'(cond_neg(64'(acc_step), mode & neg));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last)  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Datapath. p is written on the final step so it is already valid in
    // the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            mcand <= '0;
            acc   <= '0;
            neg   <= 1'b0;
            mode  <= 1'b0;
            p     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode  <= signed_mode;
                        neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        mcand <= mag_a;
                        acc   <= {{WIDTH{1'b0}}, mag_b};
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + CW'(1);
                    if (last) p <= product;
                end
                default: ;
            endcase
        end
    end

endmodule
